bram_dual_port_avmm: RTL
========================

Name: bram_dual_port_avmm

Overview:
- Parametrised true dual-port on-chip RAM with two Avalon-MM slave ports (s1, s2) on one clock.
- Next-generation replacement for the fixed 64x1024 BIDIR_DUAL_PORT buffer in the camera/BRAM path.
- Adds generic width and depth, readdatavalid/waitrequest handshakes, defined cross-port collision behaviour, and a post-reset zero-fill sweep.

Parameters:
- DATA_W, 64: data width in bits; must be a multiple of 8.
- ADDR_W, 10: word address width.
- DEPTH, 1024: number of words; must satisfy DEPTH <= 2**ADDR_W.
- BE_W, DATA_W/8: byteenable width.
- INIT_ON_RESET, 1: 1 means zero-fill all words after reset; 0 means no fill.

Ports:
- clk  in  1  single clock for both ports; reset is asynchronous, active-low.
- reset_n  in  1  asynchronous active-low reset.
- s1_address  in  ADDR_W  port 1 word address.
- s1_chipselect  in  1  port 1 select.
- s1_read  in  1  port 1 read request.
- s1_write  in  1  port 1 write request.
- s1_byteenable  in  BE_W  port 1 byte lanes.
- s1_writedata  in  DATA_W  port 1 write data.
- s1_readdata  out  DATA_W  port 1 read data.
- s1_readdatavalid  out  1  port 1 read data valid, one pulse per read.
- s1_waitrequest  out  1  port 1 stall.
- s2_* (address, chipselect, read, write, byteenable, writedata, readdata, readdatavalid, waitrequest): identical set for port 2.
- init_busy  out  1  high while the zero-fill sweep runs.

Behaviour:
- Reset (reset_n low, asynchronous):
  - all readdata = 0, readdatavalid = 0, waitrequest = 1, init_busy = 1 if INIT_ON_RESET else 0.
  - Memory array is not cleared by reset itself.
- FSM states: INIT, RUN.
  - Reset enters INIT if INIT_ON_RESET=1, otherwise RUN.
  - INIT: a counter 0..DEPTH-1 writes all-zero data, one word per clk.
  - INIT lasts exactly DEPTH cycles after reset_n deasserts; both waitrequests = 1 and init_busy = 1 throughout.
  - Leaving INIT: on the cycle after word DEPTH-1 is written, enter RUN; init_busy = 0 and waitrequest = 0.
  - With INIT_ON_RESET=0: waitrequest drops on the first clk edge after reset_n deasserts.
  - reset_n asserted during INIT aborts the sweep; the counter restarts at 0 after release.
  - RUN is held until the next reset.
- Transfer acceptance:
  - Accepted when chipselect & (read | write) & ~waitrequest.
  - In RUN, waitrequest is 0 at all times; no back-pressure.
- Reads:
  - Latency 1: readdata is updated and readdatavalid pulses for one cycle on the clk after acceptance.
  - readdata holds its value between reads.
  - Back-to-back reads on consecutive cycles give one valid pulse per cycle.
- Read and write both asserted on one port: the write is performed; no read is issued and no readdatavalid is produced.
- Writes:
  - Only byte lanes with byteenable=1 are updated.
  - byteenable = 0 means no change to the word.
- Same-port read-after-write: a read on the cycle after a write to the same address returns the new data.
- Mixed-port read-during-write (sN reads address A while the other port writes A in the same cycle): returned data is new data for enabled bytes and old data for other bytes.
- Dual write, same address, same cycle:
  - Bytes enabled on s1 take s1 data (s1 wins).
  - Bytes enabled only on s2 take s2 data.
- Out-of-range address (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Writes are dropped.
  - Reads return 0 and still produce readdatavalid.
- chipselect = 0: read and write are ignored.

Optional Feature:
- Macro: BRAM_OUTREG_EN.
- Defined: an extra output register stage on both ports.
  - Read latency becomes 2: readdata/readdatavalid appear 2 cycles after acceptance.
  - readdatavalid is pipelined alongside the data.
  - Forwarding and collision results are unchanged; only the latency changes.
- Undefined: read latency is 1 as above.

Test Plan:
- Init sweep: deassert reset_n; init_busy stays high 1024 cycles (DEPTH=1024) with waitrequest=1 on both ports; then s1 reads address 0x3FF -> readdata=0, readdatavalid pulses 1 cycle later.
- Byte write/read: s1 writes 0x1122334455667788 to 0x010 with be=0xFF, then writes 0xAA.. with be=0x01; s2 reads 0x010 -> 0x11223344556677AA at latency 1 (latency 2 with BRAM_OUTREG_EN).
- Dual write collision: same cycle, s1 writes 0xFFFF...FF with be=0x0F and s2 writes 0x0000...00 with be=0xFF to 0x020; read 0x020 -> 0x00000000FFFFFFFF.
- Mixed read-during-write: s1 writes 0xDEADBEEF_CAFEF00D to 0x030 (be=0xFF) while s2 reads 0x030 in the same cycle -> s2_readdata = 0xDEADBEEFCAFEF00D.
- Reset mid-init: assert reset_n low at sweep count 500, release -> init_busy high for a further full 1024 cycles; no accepted transfers during that time.
- Out-of-range, with DEPTH=1000 and ADDR_W=10: write 0x3F0 then read 0x3F0 -> readdata=0 with readdatavalid=1; word 0x000 unchanged.

Source files
------------

// File: rtl/bram_dual_port_avmm.sv
// bram_dual_port_avmm
// True dual-port RAM with two Avalon-MM slave ports sharing one clock.
// After reset an optional sweep writes zero to every word (INIT_ON_RESET=1);
// both ports stall through the sweep and never stall afterwards.
// Collision rules: s1 wins bytes both ports write in the same cycle; a read
// on one port sees the other port's same-cycle write for its enabled bytes.
// Optional build macro: BRAM_OUTREG_EN adds an output register stage on both
// ports, raising read latency from 1 to 2 cycles.
module bram_dual_port_avmm #(
  parameter int DATA_W        = 64,
  parameter int ADDR_W        = 10,
  parameter int DEPTH         = 1024,
  parameter int BE_W          = DATA_W / 8,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] s1_address,
  input  logic              s1_chipselect,
  input  logic              s1_read,
  input  logic              s1_write,
  input  logic [BE_W-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0] s1_writedata,
  output logic [DATA_W-1:0] s1_readdata,
  output logic              s1_readdatavalid,
  output logic              s1_waitrequest,
  input  logic [ADDR_W-1:0] s2_address,
  input  logic              s2_chipselect,
  input  logic              s2_read,
  input  logic              s2_write,
  input  logic [BE_W-1:0]   s2_byteenable,
  input  logic [DATA_W-1:0] s2_writedata,
  output logic [DATA_W-1:0] s2_readdata,
  output logic              s2_readdatavalid,
  output logic              s2_waitrequest,
  output logic              init_busy
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] init_cnt_r;
  logic              wait_r;
  logic              busy_r;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              wr1_s, wr2_s;
  logic              rd1_s, rd2_s;
  logic [DATA_W-1:0] rdata1_s, rdata2_s;

  logic [DATA_W-1:0] readdata1_r, readdata2_r;
  logic              rdv1_r, rdv2_r;

  // Overlay the enabled byte lanes of new_word onto old_word.
  function automatic logic [DATA_W-1:0] byte_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [BE_W-1:0]   be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) begin
        res[b*8 +: 8] = new_word[b*8 +: 8];
      end
    end
    return res;
  endfunction

  // True when the word address maps onto a physical word.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  // Read and write qualification; a read together with a write on the same
  // port is treated as a write only, and out-of-range writes are dropped.
  always_comb begin
    wr1_s = s1_chipselect & s1_write & ~wait_r & in_range(s1_address);
    wr2_s = s2_chipselect & s2_write & ~wait_r & in_range(s2_address);
    rd1_s = s1_chipselect & s1_read & ~s1_write & ~wait_r;
    rd2_s = s2_chipselect & s2_read & ~s2_write & ~wait_r;
  end

  // Port 1 read word: array contents with port 2's same-cycle write folded in.
  always_comb begin
    rdata1_s = '0;
    if (in_range(s1_address)) begin
      rdata1_s = mem[s1_address];
    end else begin
      rdata1_s = '0;
    end
    if (wr2_s && (s2_address == s1_address)) begin
      rdata1_s = byte_merge(rdata1_s, s2_writedata, s2_byteenable);
    end else begin
      rdata1_s = rdata1_s;
    end
  end

  // Port 2 read word: array contents with port 1's same-cycle write folded in.
  always_comb begin
    rdata2_s = '0;
    if (in_range(s2_address)) begin
      rdata2_s = mem[s2_address];
    end else begin
      rdata2_s = '0;
    end
    if (wr1_s && (s1_address == s2_address)) begin
      rdata2_s = byte_merge(rdata2_s, s1_writedata, s1_byteenable);
    end else begin
      rdata2_s = rdata2_s;
    end
  end

  // Control FSM: zero-fill sweep after reset, then permanent run state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;
      init_cnt_r <= '0;
      wait_r     <= 1'b1;
      busy_r     <= (INIT_ON_RESET != 0);
    end else begin
      case (state_r)
        ST_INIT: begin
          wait_r <= 1'b1;
          busy_r <= 1'b1;
          if (init_cnt_r == ADDR_W'(DEPTH - 1)) begin
            state_r <= ST_RUN;
            wait_r  <= 1'b0;
            busy_r  <= 1'b0;
          end else begin
            init_cnt_r <= init_cnt_r + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          wait_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: begin
          state_r <= ST_RUN;
          wait_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  // Array writes: sweep zeroes one word per clock; otherwise port 2 lanes are
  // written first so that port 1 overrides any lane both ports enable.
  always_ff @(posedge clk) begin
    if ((state_r == ST_INIT) && reset_n) begin
      mem[init_cnt_r] <= '0;
    end else begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr2_s && s2_byteenable[b]) begin
          mem[s2_address][b*8 +: 8] <= s2_writedata[b*8 +: 8];
        end
      end
      for (int b = 0; b < BE_W; b++) begin
        if (wr1_s && s1_byteenable[b]) begin
          mem[s1_address][b*8 +: 8] <= s1_writedata[b*8 +: 8];
        end
      end
    end
  end

`ifdef BRAM_OUTREG_EN
  logic [DATA_W-1:0] p1_data_r, p2_data_r;
  logic              p1_valid_r, p2_valid_r;

  // Two-stage read pipeline; data and valid travel together, data holds
  // its last value between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_data_r   <= '0;
      p2_data_r   <= '0;
      p1_valid_r  <= 1'b0;
      p2_valid_r  <= 1'b0;
      readdata1_r <= '0;
      readdata2_r <= '0;
      rdv1_r      <= 1'b0;
      rdv2_r      <= 1'b0;
    end else begin
      p1_valid_r <= rd1_s;
      p2_valid_r <= rd2_s;
      if (rd1_s) p1_data_r <= rdata1_s;
      if (rd2_s) p2_data_r <= rdata2_s;
      rdv1_r <= p1_valid_r;
      rdv2_r <= p2_valid_r;
      if (p1_valid_r) readdata1_r <= p1_data_r;
      if (p2_valid_r) readdata2_r <= p2_data_r;
    end
  end
`else
  // Single-stage read register; data holds its last value between reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata1_r <= '0;
      readdata2_r <= '0;
      rdv1_r      <= 1'b0;
      rdv2_r      <= 1'b0;
    end else begin
      rdv1_r <= rd1_s;
      rdv2_r <= rd2_s;
      if (rd1_s) readdata1_r <= rdata1_s;
      if (rd2_s) readdata2_r <= rdata2_s;
    end
  end
`endif

  assign s1_readdata      = readdata1_r;
  assign s1_readdatavalid = rdv1_r;
  assign s1_waitrequest   = wait_r;
  assign s2_readdata      = readdata2_r;
  assign s2_readdatavalid = rdv2_r;
  assign s2_waitrequest   = wait_r;
  assign init_busy        = busy_r;

endmodule
